input_debouncer: RTL and testbench
==================================

INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, is the number of consecutive clock cycles a new input level SHALL persist before acceptance (10 ms at 100 MHz); legal range 2..2^24-1.
REQ-002 Parameter CNT_W, default 24, is the counter width and SHALL satisfy 2^CNT_W > DEBOUNCE_CYCLES.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (asserted at 0).
REQ-005 btn_raw  input  1  raw asynchronous push-button / switch level.
REQ-006 signal  output  1  debounced level, registered; feeds the downstream sequence-detector serial input.
REQ-007 sig_rise  output  1  one-cycle pulse when signal goes 0->1.
REQ-008 sig_fall  output  1  one-cycle pulse when signal goes 1->0.
REQ-009 busy  output  1  high while a candidate level change is being qualified.

Function
REQ-010 btn_raw SHALL pass through a 2-flop synchronizer (sync1, sync2); only sync2 SHALL be used by the logic.
REQ-011 The FSM SHALL have four states: LOW_STABLE, WAIT_HIGH, HIGH_STABLE, WAIT_LOW.
REQ-012 LOW_STABLE: sync2=1 -> WAIT_HIGH with cnt<=1; otherwise stay with cnt<=0.
REQ-013 WAIT_HIGH: sync2=0 -> LOW_STABLE with cnt<=0 (glitch rejected, no output change); sync2=1 and cnt=DEBOUNCE_CYCLES-1 -> HIGH_STABLE, signal<=1, sig_rise<=1; otherwise cnt<=cnt+1.
REQ-014 HIGH_STABLE / WAIT_LOW SHALL mirror REQ-012/013 with levels inverted, producing signal<=0 and sig_fall<=1.
REQ-015 Latency: a raw level first captured by sync1 at edge k and held SHALL appear on signal at edge k+1+DEBOUNCE_CYCLES; sig_rise/sig_fall SHALL be asserted in the same cycle signal changes.
REQ-016 sig_rise and sig_fall SHALL be high for exactly one cycle and SHALL never be high simultaneously.
REQ-017 A bounce of any length shorter than DEBOUNCE_CYCLES consecutive cycles SHALL produce no change on signal and no pulse.
REQ-018 busy SHALL be 1 exactly in WAIT_HIGH and WAIT_LOW.
REQ-019 cnt SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap; unreachable state encodings SHALL return to LOW_STABLE with signal<=0, cnt<=0.
REQ-020 signal SHALL change only on a stable-state entry, so the downstream detector sees at most one level transition per DEBOUNCE_CYCLES cycles.

Reset
REQ-021 While rst=0: sync1=0, sync2=0, state=LOW_STABLE, cnt=0, signal=0, sig_rise=0, sig_fall=0, busy=0, independent of clk.
REQ-022 Reset asserted mid-qualification SHALL discard the candidate; no pulse SHALL be emitted on or after deassertion for it.
REQ-023 After deassertion with btn_raw held 1, signal SHALL rise through the normal REQ-015 path (no shortcut).

Structure
REQ-024 State encoding constants (2-bit LOW_STABLE=00, WAIT_HIGH=01, HIGH_STABLE=11, WAIT_LOW=10) and the DEBOUNCE_CYCLES default SHALL live in the shared input-conditioning package.
REQ-025 The synchronizer SHALL be a separate sub-module sync_2ff (parameterless, 1-bit, same clk/rst); the FSM, counter and pulse logic SHALL be in input_debouncer.

Verification (DEBOUNCE_CYCLES=4)
REQ-026 Reset then btn_raw=1 held, first captured at edge k -> signal=1 and sig_rise=1 at edge k+5; sig_rise=0 at k+6; busy high edges k+2..k+4.
REQ-027 btn_raw pulses 1 for 3 cycles then 0 -> signal stays 0, no sig_rise, busy returns to 0.
REQ-028 From signal=1, btn_raw toggles 1/0 every cycle for 20 cycles then held 0 -> exactly one sig_fall, occurring 5 edges after the final 1->0 capture.
REQ-029 rst=0 asserted while busy=1 in WAIT_HIGH, released with btn_raw=0 -> all outputs 0 immediately, no sig_rise ever.
REQ-030 Feed pattern 0,0,0 then 1,1 as debounced levels (each held 10 cycles) -> signal shows exactly 0->1 once, one sig_rise, zero sig_fall, matching downstream detector input expectations.

Source files
------------

// File: rtl/input_debouncer_pkg.sv
// input_debouncer_pkg: shared input-conditioning state encodings and defaults
package input_debouncer_pkg;
    typedef enum logic [1:0] {
        LOW_STABLE  = 2'b00,
        WAIT_HIGH   = 2'b01,
        HIGH_STABLE = 2'b11,
        WAIT_LOW    = 2'b10
    } state_t;
    localparam int DEBOUNCE_DEFAULT = 1000000;
endpackage

// File: rtl/input_debouncer_if.sv
// input_debouncer_if: raw button in, debounced level and edge pulses out
interface input_debouncer_if;
    logic btn_raw;
    logic signal;
    logic sig_rise;
    logic sig_fall;
    logic busy;
    modport master (output btn_raw, input signal, sig_rise, sig_fall, busy);
    modport slave (input btn_raw, output signal, sig_rise, sig_fall, busy);
endinterface

// File: rtl/input_debouncer_sync_2ff.sv
// sync_2ff: two-flop synchronizer for one asynchronous bit
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic sync1;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            q     <= 1'b0;
        end else begin
            sync1 <= d;
            q     <= sync1;
        end
    end
endmodule

// File: rtl/input_debouncer.sv
// input_debouncer: qualifies a raw level for DEBOUNCE_CYCLES cycles before accepting it
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = 24
) (
    input logic clk,
    input logic rst,
    input_debouncer_if.slave bus
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    logic             sync2;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             signal_q, signal_d, rise_q, rise_d, fall_q, fall_d;
    sync_2ff u_sync (.clk(clk), .rst(rst), .d(bus.btn_raw), .q(sync2));
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= LOW_STABLE;
            cnt_q    <= '0;
            signal_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            signal_q <= signal_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end
    // the counter is entered at 1, so LAST is reached after DEBOUNCE_CYCLES matching samples
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        signal_d = signal_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        case (state_q)
            LOW_STABLE: begin
                state_d = sync2 ? WAIT_HIGH : LOW_STABLE;
                cnt_d   = sync2 ? CNT_W'(1) : '0;
            end
            WAIT_HIGH: begin
                if (!sync2) begin
                    state_d = LOW_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == LAST) begin
                    state_d  = HIGH_STABLE;
                    cnt_d    = '0;
                    signal_d = 1'b1;
                    rise_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HIGH_STABLE: begin
                state_d = sync2 ? HIGH_STABLE : WAIT_LOW;
                cnt_d   = sync2 ? '0 : CNT_W'(1);
            end
            WAIT_LOW: begin
                if (sync2) begin
                    state_d = HIGH_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == LAST) begin
                    state_d  = LOW_STABLE;
                    cnt_d    = '0;
                    signal_d = 1'b0;
                    fall_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d  = LOW_STABLE;
                cnt_d    = '0;
                signal_d = 1'b0;
            end
        endcase
    end
    assign bus.signal   = signal_q;
    assign bus.sig_rise = rise_q;
    assign bus.sig_fall = fall_q;
    assign bus.busy     = (state_q == WAIT_HIGH) || (state_q == WAIT_LOW);
endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: directed vector table plus corner sequences, DEBOUNCE_CYCLES=4
module tb_input_debouncer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    input_debouncer_if bus();
    input_debouncer #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic       btn;
        logic [3:0] exp;
    } vec_t;

    vec_t tbl[28];
    int total = 0, bad = 0;
    int nr = 0, nf = 0, both = 0, tog = 0, cyc = 0, last_fall = -1;
    logic prev_sig = 1'b0;

    function automatic logic [3:0] outs();
        return {bus.signal, bus.sig_rise, bus.sig_fall, bus.busy};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task step(input logic b);
        bus.btn_raw = b;
        @(posedge clk);
        #1;
        cyc++;
        nr += int'(bus.sig_rise);
        nf += int'(bus.sig_fall);
        if (bus.sig_fall) last_fall = cyc;
        if (bus.sig_rise && bus.sig_fall) both++;
        if (bus.signal !== prev_sig) tog++;
        prev_sig = bus.signal;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int m;
        tbl = '{
            '{1'b1, 4'b0000}, '{1'b1, 4'b0000}, '{1'b1, 4'b0001}, '{1'b1, 4'b0001},
            '{1'b1, 4'b0001}, '{1'b1, 4'b1100}, '{1'b1, 4'b1000},
            '{1'b0, 4'b1000}, '{1'b0, 4'b1000}, '{1'b0, 4'b1001}, '{1'b1, 4'b1001},
            '{1'b1, 4'b1001}, '{1'b1, 4'b1000}, '{1'b1, 4'b1000},
            '{1'b0, 4'b1000}, '{1'b0, 4'b1000}, '{1'b0, 4'b1001}, '{1'b0, 4'b1001},
            '{1'b0, 4'b1001}, '{1'b0, 4'b0010}, '{1'b0, 4'b0000},
            '{1'b1, 4'b0000}, '{1'b1, 4'b0000}, '{1'b1, 4'b0001}, '{1'b0, 4'b0001},
            '{1'b0, 4'b0001}, '{1'b0, 4'b0000}, '{1'b0, 4'b0000}
        };
        bus.btn_raw = 1'b1;
        #12;
        chk("reset_outputs", 32'(outs()), 32'h0);
        bus.btn_raw = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) step(1'b0);

        for (int i = 0; i < 28; i++) begin
            step(tbl[i].btn);
            chk($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
        end

        // 20-cycle toggle from signal=1: only the final settled 0 may produce a fall
        repeat (8) step(1'b1);
        chk("toggle_start_high", 32'(bus.signal), 32'h1);
        nr = 0;
        nf = 0;
        m = 0;
        for (int i = 0; i < 20; i++) begin
            step(i % 2 == 0);
            if (i == 19) m = cyc;
        end
        repeat (10) step(1'b0);
        chk("toggle_fall_count", 32'(nf), 32'h1);
        chk("toggle_rise_count", 32'(nr), 32'h0);
        chk("toggle_fall_cycle", 32'(last_fall - m), 32'h5);

        // reset in the middle of a rising qualification
        begin
            int n = 0;
            while (!bus.busy && n < 8) begin
                step(1'b1);
                n++;
            end
        end
        chk("busy_before_rst", 32'(bus.busy), 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_outputs", 32'(outs()), 32'h0);
        bus.btn_raw = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        nr = 0;
        repeat (12) step(1'b0);
        chk("rst_no_rise", 32'(nr), 32'h0);
        chk("rst_outputs_after", 32'(outs()), 32'h0);

        // reset released with button held high: normal latency, no shortcut
        @(negedge clk);
        rst = 1'b0;
        bus.btn_raw = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        repeat (5) step(1'b1);
        chk("held_k4", 32'(outs()), 32'b0001);
        step(1'b1);
        chk("held_k5", 32'(outs()), 32'b1100);

        // debounced level stream 0,0,0,1,1 as seen by the downstream detector
        @(negedge clk);
        rst = 1'b0;
        bus.btn_raw = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        prev_sig = 1'b0;
        nr = 0;
        nf = 0;
        tog = 0;
        for (int l = 0; l < 5; l++) repeat (10) step(l >= 3);
        chk("stream_rises", 32'(nr), 32'h1);
        chk("stream_falls", 32'(nf), 32'h0);
        chk("stream_toggles", 32'(tog), 32'h1);
        chk("stream_final", 32'(bus.signal), 32'h1);
        chk("no_rise_and_fall", 32'(both), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
